// File: rtl/rib_arbiter_pkg.sv
// rib_arbiter_pkg: shared types and constants for the rib bus arbiter.
//   rib_grant_t      2-bit master index carried on the grant bus
//   rib_arb_state_e  arbiter FSM states (IDLE / BUSY / RELEASE)
//   RIB_M_*          master index constants (LSU, debug UART, reserved)
//   rib_fixed_master maps a fixed-priority rank (0 = highest) to a master index
package rib_arbiter_pkg;

  localparam int RIB_GRANT_W = 2;

  typedef logic [RIB_GRANT_W-1:0] rib_grant_t;

  typedef enum logic [1:0] {
    RIB_ARB_IDLE    = 2'b00,
    RIB_ARB_BUSY    = 2'b01,
    RIB_ARB_RELEASE = 2'b10
  } rib_arb_state_e;

  localparam rib_grant_t RIB_M_LSU = 2'd0;
  localparam rib_grant_t RIB_M_DBG = 2'd1;
  localparam rib_grant_t RIB_M_RSV = 2'd2;

  // Debug master first so a debugger can always reach the bus, then the core.
  function automatic rib_grant_t rib_fixed_master(input int rank);
    case (rank)
      0:       return RIB_M_DBG;
      1:       return RIB_M_LSU;
      2:       return RIB_M_RSV;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/rib_arb_pick.sv
// rib_arb_pick: combinational winner selector for the rib arbiter.
// Ports:
//   req_i      per-master request vector
//   start_i    first master examined in rotating mode
//   rr_mode_i  1 = rotating search from start_i, 0 = fixed priority m1>m0>m2>m3
//   winner_o   index of the selected master (0 when nothing requests)
//   any_o      at least one request is present
module rib_arb_pick
  import rib_arbiter_pkg::*;
#(
  parameter int M_NUM = 3
) (
  input  logic [M_NUM-1:0] req_i,
  input  rib_grant_t       start_i,
  input  logic             rr_mode_i,
  output rib_grant_t       winner_o,
  output logic             any_o
);

  logic [3:0] req_pad;
  int         idx;

  // Both searches walk from lowest to highest priority so the last hit wins.
  always_comb begin
    req_pad  = 4'(req_i);
    winner_o = '0;
    idx      = 0;
    any_o    = |req_i;
    if (rr_mode_i) begin
      for (int i = M_NUM - 1; i >= 0; i--) begin
        idx = (int'(start_i) + i) % M_NUM;
        if (req_pad[rib_grant_t'(idx)]) winner_o = rib_grant_t'(idx);
      end
    end else begin
      for (int k = M_NUM - 1; k >= 0; k--) begin
        if (req_pad[rib_fixed_master(k)]) winner_o = rib_fixed_master(k);
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: registered handshake arbiter sharing the rib slave side between
// masters (m0 = core LSU, m1 = uart_debug, m2 = reserved). A grant is held until
// the owner strobes done or drops its request, or until a watchdog forces release.
// Every ownership ends with a one-cycle RELEASE bubble.
// Build option: define RIB_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority m1 > m0 > m2 > m3 and no rotation pointer is built.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   m_req_i           per-master level request, held until done
//   m_done_i          per-master completion strobe (owner only)
//   grant_o           index of the owning master
//   grant_valid_o     bus currently owned by grant_o
//   rib_hold_flag_o   pipeline stall request to the core
//   timeout_o         one-cycle pulse on watchdog release
//   timeout_master_o  master released by the last watchdog event
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int M_NUM       = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M_NUM-1:0] m_req_i,
  input  logic [M_NUM-1:0] m_done_i,
  output rib_grant_t       grant_o,
  output logic             grant_valid_o,
  output logic             rib_hold_flag_o,
  output logic             timeout_o,
  output rib_grant_t       timeout_master_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  rib_arb_state_e   state_q, state_d;
  rib_grant_t       grant_q, grant_d;
  logic             gv_q, gv_d;
  logic             to_q, to_d;
  rib_grant_t       tm_q, tm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rib_grant_t       pick_start;
  logic             pick_mode;
  rib_grant_t       winner;
  logic             any_req;
  logic [3:0]       req_pad;
  logic [3:0]       done_pad;
  logic             owner_rel;

`ifdef RIB_ARB_RR_EN
  rib_grant_t rr_ptr_q, rr_ptr_d;
  assign pick_start = rib_grant_t'((int'(rr_ptr_q) + 1) % M_NUM);
  assign pick_mode  = 1'b1;
`else
  assign pick_start = '0;
  assign pick_mode  = 1'b0;
`endif

  rib_arb_pick #(.M_NUM(M_NUM)) u_pick (
    .req_i     (m_req_i),
    .start_i   (pick_start),
    .rr_mode_i (pick_mode),
    .winner_o  (winner),
    .any_o     (any_req)
  );

  // Padding keeps owner indexing in range for every supported M_NUM.
  assign req_pad   = 4'(m_req_i);
  assign done_pad  = 4'(m_done_i);
  assign owner_rel = done_pad[grant_q] | ~req_pad[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gv_d    = gv_q;
    to_d    = 1'b0;
    tm_d    = tm_q;
    cnt_d   = cnt_q;
`ifdef RIB_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      RIB_ARB_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          gv_d    = 1'b1;
          cnt_d   = '0;
          state_d = RIB_ARB_BUSY;
`ifdef RIB_ARB_RR_EN
          rr_ptr_d = winner;
`endif
        end
      end
      RIB_ARB_BUSY: begin
        // A normal release wins over the watchdog when both happen together.
        if (owner_rel) begin
          gv_d    = 1'b0;
          state_d = RIB_ARB_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          gv_d    = 1'b0;
          to_d    = 1'b1;
          tm_d    = grant_q;
          state_d = RIB_ARB_RELEASE;
        end else begin
          // Terminal count always exits BUSY, so the counter never wraps.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RIB_ARB_RELEASE: begin
        state_d = RIB_ARB_IDLE;
      end
      default: begin
        gv_d    = 1'b0;
        state_d = RIB_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RIB_ARB_IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
      to_q    <= 1'b0;
      tm_q    <= '0;
      cnt_q   <= '0;
`ifdef RIB_ARB_RR_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= gv_d;
      to_q    <= to_d;
      tm_q    <= tm_d;
      cnt_q   <= cnt_d;
`ifdef RIB_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign grant_o          = grant_q;
  assign grant_valid_o    = gv_q;
  assign timeout_o        = to_q;
  assign timeout_master_o = tm_q;

  // Stall the core while another master owns the bus, or while the core
  // requests but does not yet own it.
  assign rib_hold_flag_o = (gv_q && (grant_q != RIB_M_LSU)) ||
                           (m_req_i[0] && !(gv_q && (grant_q == RIB_M_LSU)));

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: self-checking bench for rib_arbiter (vector table, directed
// corner sequences and randomized traffic against a behavioural model).
module tb_rib_arbiter;

  localparam int M  = 3;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] m_req_i;
  logic [2:0] m_done_i;
  logic [1:0] grant_o;
  logic       grant_valid_o;
  logic       rib_hold_flag_o;
  logic       timeout_o;
  logic [1:0] timeout_master_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who owns the bus, how long, and the turnaround bubble.
  bit m_owned  = 0;
  int m_owner  = 0;
  bit m_bubble = 0;
  int m_busy   = 0;
  bit m_to     = 0;
  int m_tm     = 0;
  int m_last   = 0;

  rib_arbiter #(.M_NUM(M), .TIMEOUT_CYC(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .m_req_i          (m_req_i),
    .m_done_i         (m_done_i),
    .grant_o          (grant_o),
    .grant_valid_o    (grant_valid_o),
    .rib_hold_flag_o  (rib_hold_flag_o),
    .timeout_o        (timeout_o),
    .timeout_master_o (timeout_master_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int last);
    int order[4];
    order = '{1, 0, 2, 3};
`ifdef RIB_ARB_RR_EN
    for (int i = 1; i <= M; i++) begin
      if (r[(last + i) % M]) return (last + i) % M;
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (order[k] < M && r[order[k]]) return order[k];
    end
`endif
    return last - last;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] req, input logic [2:0] done);
    if (r) begin
      m_owned = 0; m_owner = 0; m_bubble = 0; m_busy = 0;
      m_to = 0; m_tm = 0; m_last = 0;
    end else begin
      m_to = 0;
      if (m_bubble) begin
        m_bubble = 0;
      end else if (m_owned) begin
        if (done[m_owner] || !req[m_owner]) begin
          m_owned = 0; m_bubble = 1;
        end else if (m_busy == TO - 1) begin
          m_owned = 0; m_bubble = 1; m_to = 1; m_tm = m_owner;
        end else begin
          m_busy++;
        end
      end else if (req != 3'b000) begin
        m_owner = pick(req, m_last);
        m_last  = m_owner;
        m_owned = 1;
        m_busy  = 0;
      end
    end
  endtask

  // Apply inputs, let one edge pass, then compare against the model.
  task automatic cycle(input logic r, input logic [2:0] req, input logic [2:0] done);
    bit exp_hold;
    rst = r; m_req_i = req; m_done_i = done;
    @(posedge clk);
    model_step(r, req, done);
    #1;
    exp_hold = (m_owned && m_owner != 0) || (req[0] && !(m_owned && m_owner == 0));
    chk("model_gv", int'(grant_valid_o), int'(m_owned));
    if (m_owned) chk("model_grant", int'(grant_o), m_owner);
    chk("model_timeout", int'(timeout_o), int'(m_to));
    chk("model_tmaster", int'(timeout_master_o), m_tm);
    chk("model_hold", int'(rib_hold_flag_o), int'(exp_hold));
  endtask

  typedef struct {
    logic       r;
    logic [2:0] req;
    logic [2:0] done;
    logic       gv;
    logic [1:0] g;
    logic       to;
    logic       hold;
  } vec_t;

  vec_t tbl[18];
  int   exp_seq[4];
  logic [2:0] rq, dn;

  initial begin
    rst = 1'b1; m_req_i = 3'b000; m_done_i = 3'b000;

    // reset with 011 held, first grant, then release sequences
    tbl[0]  = '{1'b1, 3'b011, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 3'b011, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 3'b011, 3'b000, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 3'b001, 3'b000, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 3'b001, 3'b000, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3'b001, 3'b000, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 3'b001, 3'b001, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 3'b001, 3'b000, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 3'b011, 3'b000, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 3'b011, 3'b001, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 3'b010, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 3'b010, 3'b000, 1'b1, 2'd1, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].r, tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d_gv", i), int'(grant_valid_o), int'(tbl[i].gv));
      if (tbl[i].gv) chk($sformatf("vec%0d_grant", i), int'(grant_o), int'(tbl[i].g));
      chk($sformatf("vec%0d_timeout", i), int'(timeout_o), int'(tbl[i].to));
      chk($sformatf("vec%0d_hold", i), int'(rib_hold_flag_o), int'(tbl[i].hold));
    end

    // watchdog: m2 never strobes done
    cycle(1'b1, 3'b000, 3'b000);
    chk("rst_tmaster", int'(timeout_master_o), 0);
    cycle(1'b0, 3'b100, 3'b000);
    chk("wd_grant", int'(grant_o), 2);
    for (int i = 1; i < TO; i++) begin
      cycle(1'b0, 3'b100, 3'b000);
      chk("wd_busy_gv", int'(grant_valid_o), 1);
      chk("wd_busy_to", int'(timeout_o), 0);
    end
    cycle(1'b0, 3'b100, 3'b000);
    chk("wd_fire_to", int'(timeout_o), 1);
    chk("wd_fire_gv", int'(grant_valid_o), 0);
    chk("wd_fire_tm", int'(timeout_master_o), 2);
    cycle(1'b0, 3'b100, 3'b000);
    chk("wd_pulse_once", int'(timeout_o), 0);
    chk("wd_bubble_gv", int'(grant_valid_o), 0);
    chk("wd_tm_held", int'(timeout_master_o), 2);
    cycle(1'b0, 3'b100, 3'b000);
    chk("wd_regrant", int'(grant_valid_o), 1);
    // done coinciding with the terminal cycle is a normal release
    for (int i = 1; i < TO; i++) cycle(1'b0, 3'b100, 3'b000);
    cycle(1'b0, 3'b100, 3'b100);
    chk("wd_done_last_to", int'(timeout_o), 0);
    chk("wd_done_last_gv", int'(grant_valid_o), 0);
    cycle(1'b0, 3'b000, 3'b000);

    // reset during BUSY with done high: no bubble afterwards
    cycle(1'b0, 3'b010, 3'b000);
    cycle(1'b0, 3'b010, 3'b000);
    cycle(1'b1, 3'b010, 3'b010);
    chk("rstbusy_gv", int'(grant_valid_o), 0);
    chk("rstbusy_to", int'(timeout_o), 0);
    cycle(1'b0, 3'b010, 3'b000);
    chk("rstbusy_regrant_gv", int'(grant_valid_o), 1);
    chk("rstbusy_regrant_g", int'(grant_o), 1);
    cycle(1'b0, 3'b000, 3'b000);
    cycle(1'b0, 3'b000, 3'b000);

    // all masters requesting, each owner done after one cycle
`ifdef RIB_ARB_RR_EN
    exp_seq = '{1, 2, 0, 1};
`else
    exp_seq = '{1, 1, 1, 1};
`endif
    cycle(1'b1, 3'b000, 3'b000);
    for (int n = 0; n < 4; n++) begin
      cycle(1'b0, 3'b111, 3'b000);
      chk($sformatf("seq%0d_gv", n), int'(grant_valid_o), 1);
      chk($sformatf("seq%0d_grant", n), int'(grant_o), exp_seq[n]);
      dn = 3'b001 << grant_o;
      cycle(1'b0, 3'b111, dn);
      cycle(1'b0, 3'b111, 3'b000);
    end

    // randomized traffic
    cycle(1'b1, 3'b000, 3'b000);
    rq = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 3'($urandom);
      dn = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      cycle(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0, rq, dn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
